id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with built-in load-use hazard detection.
- Sits directly upstream of the EX-stage 32-bit ALU operand 2:1 mux.
- Its registered outputs drive that mux: ex_rs2_data feeds w0, ex_imm feeds w1, and ex_alusrc feeds the select s.
- Captures decoded operands and controls each cycle. It holds on a downstream stall, inserts a bubble on a load-use hazard, and clears on a branch flush.

Parameters:
- DATA_W, 32, width of operand and immediate buses.
- RA_W, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a valid instruction
- id_rs1  input  RA_W  source register 1 address
- id_rs2  input  RA_W  source register 2 address
- id_uses_rs2  input  1  instruction reads rs2 (R-type/store/branch)
- id_rd  input  RA_W  destination register
- id_rs1_data  input  DATA_W  register-file read 1
- id_rs2_data  input  DATA_W  register-file read 2
- id_imm  input  DATA_W  sign-extended immediate
- id_alusrc  input  1  1 = immediate operand
- id_regwrite  input  1  control
- id_memread  input  1  control
- id_memwrite  input  1  control
- id_memtoreg  input  1  control
- flush  input  1  branch redirect; kill the ID instruction
- ex_stall  input  1  EX/MEM cannot accept; hold contents
- hazard_stall  output  1  combinational; freezes PC and IF/ID
- ex_valid  output  1  registered valid
- ex_rs1, ex_rs2, ex_rd  output  RA_W  registered addresses (used for forwarding)
- ex_rs1_data, ex_rs2_data, ex_imm  output  DATA_W  registered data
- ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  output  1  registered controls

Behaviour:
- Clocking and reset
  - Single clock; reset is synchronous and active-high, port rst.
  - All registered outputs are 0 on reset.
- Hazard detection (combinational)
  - hazard_stall = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
  - hazard_stall is forced to 0 while flush = 1 or rst = 1.
- Register update priority, evaluated at each rising edge:
  1. rst: clear all registers.
  2. flush: ex_valid <= 0 and all five controls <= 0. Data/address fields are don't-care; they are held. Flush wins over ex_stall.
  3. ex_stall: hold every register. hazard_stall may stay asserted across the stall.
  4. hazard_stall: bubble. ex_valid <= 0, controls <= 0, data held.
  5. Otherwise load all fields from ID.
     - ex_valid <= id_valid.
     - Controls are captured ANDed with id_valid, so an invalid slot carries no side effects.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Load-use timing
  - A load followed immediately by a dependent instruction produces exactly one bubble.
  - The next cycle the load has left EX, the hazard clears, and the dependent instruction loads.
- rd = 0 (x0) never triggers a hazard.
- A hazard against a non-load (ex_memread = 0) never stalls; forwarding handles it.
- rst mid-stall or mid-bubble
  - Next cycle all outputs are 0 and hazard_stall = 0.
- Data registers are not reset-gated beyond rst. Downstream qualifies everything with ex_valid.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds output bubble_cnt [31:0].
  - Increments on every cycle a hazard bubble is inserted: priority 4 taken, i.e. not flush, not ex_stall.
  - Saturates at 0xFFFFFFFF; cleared by rst.
  - Flush cycles are not counted.
- Undefined:
  - Port and counter absent.
  - Behaviour otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all ex_* = 0, hazard_stall = 0. Release rst with id_valid = 1, id_rs2_data = 0x11, id_imm = 0x22, id_alusrc = 1 -> next cycle ex_imm = 0x22, ex_alusrc = 1, ex_valid = 1.
- Load-use:
  - Stimulus: load lw rd=5 into EX (ex_memread = 1); present ID rs1 = 5.
  - Required: hazard_stall = 1 that cycle. Next edge ex_valid = 0 with controls 0. Following edge the dependent instruction loads and hazard_stall = 0.
- rs2 gating:
  - ex_rd = 5 load in EX; ID rs2 = 5 with id_uses_rs2 = 0 -> hazard_stall = 0.
  - Same with id_uses_rs2 = 1 -> hazard_stall = 1.
  - ex_rd = 0 with matching rs1 = 0 -> hazard_stall = 0.
- Stall hold: ex_stall = 1 for 3 cycles while ID inputs change each cycle -> ex_* unchanged from the pre-stall values (e.g. ex_rs1_data = 0xDEADBEEF) for all 3 cycles.
- Flush priority: flush = 1 together with ex_stall = 1 and a pending hazard -> next cycle ex_valid = 0, all controls 0, hazard_stall = 0 during the flush.
- Perf counter (ID_EX_PERF_CNT_EN): 4 separate load-use pairs plus 1 flush -> bubble_cnt = 4. Preload near saturation via force to 0xFFFFFFFF, then one more bubble -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall hold and flush bubble.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_uses_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  // Control vector order: {alusrc, regwrite, memread, memwrite, memtoreg}
  localparam int CTRL_MR = 2;

  logic              valid_q,    valid_d;
  logic [RA_W-1:0]   rs1_q,      rs1_d;
  logic [RA_W-1:0]   rs2_q,      rs2_d;
  logic [RA_W-1:0]   rd_q,       rd_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [4:0]        ctrl_q,     ctrl_d;
  logic              hazard_s;

  always_comb begin
    hazard_s = 1'b0;
    if (rst || flush) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = id_valid && valid_q && ctrl_q[CTRL_MR] &&
                 (rd_q != {RA_W{1'b0}}) &&
                 ((rd_q == id_rs1) || (id_uses_rs2 && (rd_q == id_rs2)));
    end
  end

  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = 5'b0_0000;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (hazard_s) begin
      // Bubble: kill valid and side effects, leave data fields as they were
      valid_d = 1'b0;
      ctrl_d  = 5'b0_0000;
    end else begin
      valid_d    = id_valid;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      ctrl_d     = {id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg} & {5{id_valid}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_q      <= {RA_W{1'b0}};
      rs2_q      <= {RA_W{1'b0}};
      rd_q       <= {RA_W{1'b0}};
      rs1_data_q <= {DATA_W{1'b0}};
      rs2_data_q <= {DATA_W{1'b0}};
      imm_q      <= {DATA_W{1'b0}};
      ctrl_q     <= 5'b0_0000;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts only bubbles actually inserted; saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 32'h0000_0000;
    end else if (!flush && !ex_stall && hazard_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'h0000_0001;
    end else begin
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign hazard_stall = hazard_s;
  assign ex_valid     = valid_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_alusrc    = ctrl_q[4];
  assign ex_regwrite  = ctrl_q[3];
  assign ex_memread   = ctrl_q[2];
  assign ex_memwrite  = ctrl_q[1];
  assign ex_memtoreg  = ctrl_q[0];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard/stall/flush steps plus
// random traffic against a field-level model of the EX slot.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs2, flush, ex_stall;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        hazard_stall, ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alusrc, rw, mr, mw, mtr;
  } ex_t;

  ex_t         m;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .flush(flush), .ex_stall(ex_stall),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load-use rule straight from the pipeline definition, using the modelled EX slot
  function automatic logic exp_hz();
    if (rst || flush) return 1'b0;
    return id_valid && m.v && m.mr && (m.rd != 5'd0) &&
           ((m.rd == id_rs1) || (id_uses_rs2 && (m.rd == id_rs2)));
  endfunction

  task automatic check_outputs();
    chk("ex_valid",    32'(ex_valid),    32'(m.v));
    chk("ex_rs1",      32'(ex_rs1),      32'(m.rs1));
    chk("ex_rs2",      32'(ex_rs2),      32'(m.rs2));
    chk("ex_rd",       32'(ex_rd),       32'(m.rd));
    chk("ex_rs1_data", ex_rs1_data,      m.d1);
    chk("ex_rs2_data", ex_rs2_data,      m.d2);
    chk("ex_imm",      ex_imm,           m.imm);
    chk("ex_ctrl", 32'({ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
                   32'({m.alusrc, m.rw, m.mr, m.mw, m.mtr}));
`ifdef ID_EX_PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_cnt);
`endif
  endtask

  task automatic cycle();
    logic h;
    ex_t  n;
    @(negedge clk);
    h = exp_hz();
    chk("hazard_stall", 32'(hazard_stall), 32'(h));
    n = m;
    if (rst) begin
      n = '0;
      m_cnt = 32'd0;
    end else if (flush) begin
      n.v = 1'b0; n.alusrc = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.mtr = 1'b0;
    end else if (ex_stall) begin
      n = m;
    end else if (h) begin
      n.v = 1'b0; n.alusrc = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.mtr = 1'b0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else begin
      n.v = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
      n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
      n.alusrc = id_alusrc & id_valid;  n.rw  = id_regwrite & id_valid;
      n.mr     = id_memread & id_valid; n.mw  = id_memwrite & id_valid;
      n.mtr    = id_memtoreg & id_valid;
    end
    @(posedge clk);
    #1;
    m = n;
    check_outputs();
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 9) < 8);
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_uses_rs2 = 1'($urandom);
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_alusrc   = 1'($urandom);
    id_regwrite = 1'($urandom);
    id_memread  = 1'($urandom);
    id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom);
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic [4:0] rd, input logic mr);
    rand_id();
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses; id_rd = rd;
    id_memread = mr; id_memtoreg = mr; id_regwrite = 1'b1; id_memwrite = 1'b0;
  endtask

  initial begin
    m = '0; m_cnt = 32'd0;
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    rand_id();

    // Reset with random inputs
    repeat (2) begin rand_id(); cycle(); end
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    rst = 1'b0;
    instr(5'd1, 5'd2, 1'b0, 5'd3, 1'b0);
    id_rs2_data = 32'h11; id_imm = 32'h22; id_alusrc = 1'b1;
    cycle();
    chk("rel_imm", ex_imm, 32'h22);
    chk("rel_alusrc", 32'(ex_alusrc), 32'd1);
    chk("rel_valid", 32'(ex_valid), 32'd1);

    // Load-use: exactly one bubble
    instr(5'd1, 5'd2, 1'b0, 5'd5, 1'b1); cycle();
    instr(5'd5, 5'd2, 1'b0, 5'd6, 1'b0); #1;
    chk("lu_hz", 32'(hazard_stall), 32'd1);
    cycle();
    chk("lu_bubble_v", 32'(ex_valid), 32'd0);
    chk("lu_bubble_mr", 32'(ex_memread), 32'd0);
    cycle();
    chk("lu_dep_rd", 32'(ex_rd), 32'd6);
    chk("lu_dep_v", 32'(ex_valid), 32'd1);

    // rs2 gating while the load is held in EX
    instr(5'd1, 5'd2, 1'b0, 5'd5, 1'b1); cycle();
    ex_stall = 1'b1;
    instr(5'd3, 5'd5, 1'b0, 5'd7, 1'b0); #1;
    chk("rs2_nouse_hz", 32'(hazard_stall), 32'd0);
    cycle();
    instr(5'd3, 5'd5, 1'b1, 5'd7, 1'b0); #1;
    chk("rs2_use_hz", 32'(hazard_stall), 32'd1);
    cycle();
    ex_stall = 1'b0;
    instr(5'd9, 5'd9, 1'b0, 5'd0, 1'b1); cycle();
    instr(5'd0, 5'd0, 1'b1, 5'd8, 1'b0); #1;
    chk("x0_hz", 32'(hazard_stall), 32'd0);
    cycle();

    // Stall hold for 3 cycles
    instr(5'd1, 5'd2, 1'b0, 5'd3, 1'b0); id_rs1_data = 32'hDEADBEEF; cycle();
    ex_stall = 1'b1;
    repeat (3) begin
      rand_id(); cycle();
      chk("hold_d1", ex_rs1_data, 32'hDEADBEEF);
    end
    ex_stall = 1'b0;

    // Flush beats stall and pending hazard
    instr(5'd1, 5'd2, 1'b0, 5'd7, 1'b1); cycle();
    flush = 1'b1; ex_stall = 1'b1;
    instr(5'd7, 5'd7, 1'b1, 5'd4, 1'b0); #1;
    chk("fl_hz", 32'(hazard_stall), 32'd0);
    cycle();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_ctrl", 32'({ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // Reset in the middle of a bubble
    instr(5'd1, 5'd2, 1'b0, 5'd4, 1'b1); cycle();
    instr(5'd4, 5'd2, 1'b0, 5'd6, 1'b0); cycle();
    rst = 1'b1; cycle();
    chk("rstmid_valid", 32'(ex_valid), 32'd0);
    chk("rstmid_rd", 32'(ex_rd), 32'd0);
    rst = 1'b0; cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 10);
      ex_stall = ($urandom_range(0, 99) < 15);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (4) begin
      instr(5'd1, 5'd2, 1'b0, 5'd5, 1'b1); cycle();
      instr(5'd5, 5'd2, 1'b0, 5'd6, 1'b0); cycle(); cycle();
    end
    instr(5'd1, 5'd2, 1'b0, 5'd5, 1'b1); cycle();
    flush = 1'b1; instr(5'd5, 5'd2, 1'b0, 5'd6, 1'b0); cycle(); flush = 1'b0;
    chk("cnt4", bubble_cnt, 32'd4);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.bubble_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    instr(5'd1, 5'd2, 1'b0, 5'd5, 1'b1); cycle();
    instr(5'd5, 5'd2, 1'b0, 5'd6, 1'b0); cycle();
    chk("cnt_sat", bubble_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
